// File: rtl/if_id_flush_stage.sv
// if_id_flush_stage
//   Fetch-side PC register and IF/ID pipeline register.
//   A flush redirects the PC to a word-aligned branch target and squashes the
//   IF/ID slot to a NOP bubble. A stall holds the PC and the slot. Flush cycles
//   are counted in a saturating counter for performance debug.
//   All outputs come straight from registers, so no input reaches an output
//   within the same cycle.
module if_id_flush_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush,
  input  logic [XLEN-1:0]  BranchTarget,
  input  logic             Stall,
  input  logic [31:0]      InstrMemData,
  output logic [XLEN-1:0]  FetchPC,
  output logic [XLEN-1:0]  IFID_PC,
  output logic [31:0]      IFID_Instr,
  output logic             IFID_Valid,
  output logic             Misaligned,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0]  PC_ZERO  = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // A redirect target is misaligned when either low address bit is set.
  function automatic logic target_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

  // Force a redirect target onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  logic [XLEN-1:0]  fetch_pc_r;
  logic [XLEN-1:0]  ifid_pc_r;
  logic [31:0]      ifid_instr_r;
  logic             ifid_valid_r;
  logic             misaligned_r;
  logic [CNT_W-1:0] flush_count_r;

  // PC register: flush redirects, stall holds, otherwise step one word (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
    end else if (Flush) begin
      fetch_pc_r <= align_word(BranchTarget);
    end else if (Stall) begin
      fetch_pc_r <= fetch_pc_r;
    end else begin
      fetch_pc_r <= fetch_pc_r + PC_STEP;
    end
  end

  // IF/ID slot: flush injects a NOP bubble, stall holds, otherwise capture fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_r    <= PC_ZERO;
      ifid_instr_r <= NOP_INSTR;
      ifid_valid_r <= 1'b0;
    end else if (Flush) begin
      ifid_pc_r    <= PC_ZERO;
      ifid_instr_r <= NOP_INSTR;
      ifid_valid_r <= 1'b0;
    end else if (Stall) begin
      ifid_pc_r    <= ifid_pc_r;
      ifid_instr_r <= ifid_instr_r;
      ifid_valid_r <= ifid_valid_r;
    end else begin
      ifid_pc_r    <= fetch_pc_r;
      ifid_instr_r <= InstrMemData;
      ifid_valid_r <= 1'b1;
    end
  end

  // Misaligned pulse: set only in the cycle after a redirect with low bits set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_r <= 1'b0;
    end else if (Flush) begin
      misaligned_r <= target_misaligned(BranchTarget[1:0]);
    end else begin
      misaligned_r <= 1'b0;
    end
  end

  // Flush counter: one per flush cycle, sticks at all-ones once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_count_r <= CNT_ZERO;
    end else if (Flush && (flush_count_r != CNT_MAX)) begin
      flush_count_r <= flush_count_r + CNT_ONE;
    end else begin
      flush_count_r <= flush_count_r;
    end
  end

  assign FetchPC    = fetch_pc_r;
  assign IFID_PC    = ifid_pc_r;
  assign IFID_Instr = ifid_instr_r;
  assign IFID_Valid = ifid_valid_r;
  assign Misaligned = misaligned_r;
  assign FlushCount = flush_count_r;

endmodule

// File: tb/tb_if_id_flush_stage.sv
// tb_if_id_flush_stage
//   Directed bench for if_id_flush_stage. Instruction memory is a bench-side
//   combinational function of the fetch address, so every expected IF/ID
//   instruction can be written down from the address alone.
module tb_if_id_flush_stage;

  logic        clk;
  logic        rst_n;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic [31:0] InstrMemData;
  logic [31:0] FetchPC;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic        Misaligned;
  logic [15:0] FlushCount;

  int n_checks;
  int n_fail;

  if_id_flush_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Flush        (Flush),
    .BranchTarget (BranchTarget),
    .Stall        (Stall),
    .InstrMemData (InstrMemData),
    .FetchPC      (FetchPC),
    .IFID_PC      (IFID_PC),
    .IFID_Instr   (IFID_Instr),
    .IFID_Valid   (IFID_Valid),
    .Misaligned   (Misaligned),
    .FlushCount   (FlushCount)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return addr ^ 32'hA5C3_0000;
  endfunction

  // Combinational instruction memory read at the current fetch address.
  assign InstrMemData = imem(FetchPC);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".FetchPC"},    FetchPC,           32'h0000_0000);
    check({tag, ".IFID_PC"},    IFID_PC,           32'h0000_0000);
    check({tag, ".IFID_Instr"}, IFID_Instr,        32'h0000_0013);
    check({tag, ".IFID_Valid"}, {31'd0, IFID_Valid}, 32'd0);
    check({tag, ".Misaligned"}, {31'd0, Misaligned}, 32'd0);
    check({tag, ".FlushCount"}, {16'd0, FlushCount}, 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    Flush        = 1'b0;
    Stall        = 1'b0;
    BranchTarget = 32'h0000_0000;

    // 1: reset state, then four plain advances.
    step();
    step();
    check_reset_state("rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("t1.FetchPC%0d", i), FetchPC, 32'(4 * i));
      check($sformatf("t1.IFID_PC%0d", i), IFID_PC, 32'(4 * (i - 1)));
      check($sformatf("t1.Instr%0d", i), IFID_Instr, imem(32'(4 * (i - 1))));
      check($sformatf("t1.Valid%0d", i), {31'd0, IFID_Valid}, 32'd1);
    end

    // 2: flush to 0x40 from FetchPC 0x10.
    Flush = 1'b1; BranchTarget = 32'h0000_0040;
    step();
    check("t2.FetchPC", FetchPC, 32'h0000_0040);
    check("t2.Instr",   IFID_Instr, 32'h0000_0013);
    check("t2.IFID_PC", IFID_PC, 32'h0000_0000);
    check("t2.Valid",   {31'd0, IFID_Valid}, 32'd0);
    check("t2.Count",   {16'd0, FlushCount}, 32'd1);
    check("t2.Mis",     {31'd0, Misaligned}, 32'd0);
    Flush = 1'b0;
    step();
    check("t2.IFID_PC2", IFID_PC, 32'h0000_0040);
    check("t2.Valid2",   {31'd0, IFID_Valid}, 32'd1);
    check("t2.Instr2",   IFID_Instr, imem(32'h0000_0040));
    check("t2.FetchPC2", FetchPC, 32'h0000_0044);

    // 3: flush and stall together, flush wins.
    Flush = 1'b1; Stall = 1'b1; BranchTarget = 32'h0000_0080;
    step();
    check("t3.FetchPC", FetchPC, 32'h0000_0080);
    check("t3.Instr",   IFID_Instr, 32'h0000_0013);
    check("t3.Valid",   {31'd0, IFID_Valid}, 32'd0);
    check("t3.Count",   {16'd0, FlushCount}, 32'd2);
    Stall = 1'b0;

    // 4: reach FetchPC 0x20 with 0x1C in IF/ID, then stall three cycles.
    BranchTarget = 32'h0000_001C;
    step();
    Flush = 1'b0;
    step();
    check("t4.pre.FetchPC", FetchPC, 32'h0000_0020);
    check("t4.pre.IFID_PC", IFID_PC, 32'h0000_001C);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4.FetchPC%0d", i), FetchPC, 32'h0000_0020);
      check($sformatf("t4.IFID_PC%0d", i), IFID_PC, 32'h0000_001C);
      check($sformatf("t4.Instr%0d", i), IFID_Instr, imem(32'h0000_001C));
      check($sformatf("t4.Valid%0d", i), {31'd0, IFID_Valid}, 32'd1);
      check($sformatf("t4.Count%0d", i), {16'd0, FlushCount}, 32'd3);
    end
    Stall = 1'b0;
    step();
    check("t4.post.FetchPC", FetchPC, 32'h0000_0024);
    check("t4.post.IFID_PC", IFID_PC, 32'h0000_0020);

    // 5: PC wrap at the top of the address space, then misaligned redirect.
    Flush = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step();
    check("t5.FetchPCtop", FetchPC, 32'hFFFF_FFFC);
    Flush = 1'b0;
    step();
    check("t5.wrap",      FetchPC, 32'h0000_0000);
    check("t5.IFID_PC",   IFID_PC, 32'hFFFF_FFFC);
    Flush = 1'b1; BranchTarget = 32'h0000_0043;
    step();
    check("t5.FetchPCmis", FetchPC, 32'h0000_0040);
    check("t5.Mis1",       {31'd0, Misaligned}, 32'd1);
    check("t5.Count",      {16'd0, FlushCount}, 32'd5);
    Flush = 1'b0;
    step();
    check("t5.Mis2",       {31'd0, Misaligned}, 32'd0);
    check("t5.IFID_PC2",   IFID_PC, 32'h0000_0040);
    check("t5.FetchPC2",   FetchPC, 32'h0000_0044);

    // Consecutive flushes: the last target wins and both count.
    Flush = 1'b1; BranchTarget = 32'h0000_0200;
    step();
    BranchTarget = 32'h0000_0300;
    step();
    check("cf.FetchPC", FetchPC, 32'h0000_0300);
    check("cf.Count",   {16'd0, FlushCount}, 32'd7);
    Flush = 1'b0;
    step();
    check("cf.IFID_PC", IFID_PC, 32'h0000_0300);

    // 6: asynchronous reset between edges with a redirect pending on inputs.
    Flush = 1'b1; BranchTarget = 32'h0000_0100;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    step();
    check_reset_state("midrst.held");
    Flush = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("rel.FetchPC", FetchPC, 32'h0000_0004);
    check("rel.IFID_PC", IFID_PC, 32'h0000_0000);
    check("rel.Instr",   IFID_Instr, imem(32'h0000_0000));
    check("rel.Valid",   {31'd0, IFID_Valid}, 32'd1);

    // Counter saturation: bring the count to 0xFFFE, then three more flushes.
    Flush = 1'b1; BranchTarget = 32'h0000_0000;
    for (int i = 0; i < 65534; i++) begin
      step();
    end
    check("sat.FFFE", {16'd0, FlushCount}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat.%0d", i), {16'd0, FlushCount}, 32'h0000_FFFF);
    end
    Flush = 1'b0;
    step();
    check("sat.hold", {16'd0, FlushCount}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
